// File: rtl/bitwise_logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight ops on a/b, valid/ready on both sides.
// Define LOGIC_FLAGS_EN to add registered zero_flag/ones_flag outputs.
module bitwise_logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] xfer_cnt
`ifdef LOGIC_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             ones_flag
`endif
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] sv;
    logic [STAGES-1:0] hi;
    logic [WIDTH-1:0]  d  [STAGES];
    logic [WIDTH-1:0]  sd [STAGES];
    logic [WIDTH-1:0]  res;
    logic [CNT_W-1:0]  cnt;

    always_comb begin
        res = '0;
        unique case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: res = a ^ b;
            3'b011: res = ~(a ^ b);
            3'b100: res = ~(a & b);
            3'b101: res = ~(a | b);
            3'b110: res = ~a;
            3'b111: res = a;
        endcase
    end

    // Stage i may load unless it and every stage after it is full
    // while the output is stalled.
    always_comb begin
        en = '0;
        hi = '0;
        for (int i = 0; i < STAGES; i++) begin
            hi    = {STAGES{1'b1}} << i;
            en[i] = out_ready || ((v & hi) != hi);
        end
    end

    always_comb begin
        sv    = '0;
        sv[0] = in_valid;
        for (int i = 0; i < STAGES; i++) begin
            sd[i] = res;
        end
        for (int i = 1; i < STAGES; i++) begin
            sv[i] = v[i-1];
            sd[i] = d[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (en[i]) begin
                    v[i] <= sv[i];
                    if (sv[i]) begin
                        d[i] <= sd[i];
                    end
                end
            end
            if (v[STAGES-1] && out_ready) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef LOGIC_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
            ones_flag <= 1'b0;
        end else if (en[STAGES-1] && sv[STAGES-1]) begin
            zero_flag <= ~|sd[STAGES-1];
            ones_flag <= &sd[STAGES-1];
        end
    end
`endif

    assign in_ready  = en[0];
    assign out_valid = v[STAGES-1];
    assign y         = d[STAGES-1];
    assign xfer_cnt  = cnt;

endmodule
